// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and default width for the bit-serial adder
package serial_adder_pkg;
  localparam int SA_DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle; SERIAL_ADDER_OVF_EN adds the ovf result bit
interface serial_adder_if #(parameter int WIDTH = serial_adder_pkg::SA_DEFAULT_WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, busy, ovf);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy, ovf);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, busy);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/sa_bit_slice.sv
// sa_bit_slice: one-bit full adder with the running carry flop
module sa_bit_slice (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  input  logic din,
  input  logic a,
  input  logic b,
  output logic s,
  output logic co,
  output logic carry
);
  assign s  = a ^ b ^ carry;
  assign co = (a & b) | ((a ^ b) & carry);
  // carry is seeded with cin on accept, then advances once per shifted bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) carry <= 1'b0;
    else if (load) carry <= din;
    else if (en) carry <= co;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, WIDTH cycles per operation; SERIAL_ADDER_OVF_EN adds ovf
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, sh_q, sum_q, sh_nx;
  logic [CW-1:0]    cnt;
  logic             cout_q, s, co, carry, accept, shifting, last;
  assign accept   = (state == IDLE) && bus.in_valid;
  assign shifting = (state == SHIFT);
  assign last     = shifting && (cnt == CW'(WIDTH - 1));
  assign sh_nx    = WIDTH'({s, sh_q} >> 1);
  sa_bit_slice u_slice (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (shifting),
    .din   (bus.cin),
    .a     (a_q[0]),
    .b     (b_q[0]),
    .s     (s),
    .co    (co),
    .carry (carry)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: accept in IDLE, WIDTH shift cycles, hold result until consumed
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.in_valid ? SHIFT : IDLE;
      SHIFT:   state_nx = last ? DONE : SHIFT;
      DONE:    state_nx = bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // operand shift registers, bit counter, and a separate result copy so sum stays stable while shifting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sh_q   <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b;
      cnt <= '0;
    end else if (shifting) begin
      a_q  <= a_q >> 1;
      b_q  <= b_q >> 1;
      sh_q <= sh_nx;
      cnt  <= cnt + 1'b1;
      if (last) begin
        sum_q  <= sh_nx;
        cout_q <= co;
      end
    end
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  // on the last shift the carry flop holds the carry into the MSB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else if (last) ovf_q <= carry ^ co;
  assign bus.ovf = ovf_q;
`endif
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table vectors, hold/reset corners and random ops on WIDTH=8 and WIDTH=16 instances
module tb_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0, iv = 1'b0, ordy = 1'b0, cin_drv = 1'b0;
  logic [15:0] a_drv = '0, b_drv = '0;
  int          tests = 0, fails = 0;
  logic [16:0] sbq[$];
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  b8 ();
  serial_adder_if #(.WIDTH(16)) b16 ();

  assign b8.in_valid   = iv & ~sel;
  assign b8.a          = a_drv[7:0];
  assign b8.b          = b_drv[7:0];
  assign b8.cin        = cin_drv;
  assign b8.out_ready  = ordy & ~sel;
  assign b16.in_valid  = iv & sel;
  assign b16.a         = a_drv;
  assign b16.b         = b_drv;
  assign b16.cin       = cin_drv;
  assign b16.out_ready = ordy & sel;

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  logic        cur_ir, cur_ov, cur_cout;
  logic [15:0] cur_sum;
  assign cur_ir   = sel ? b16.in_ready  : b8.in_ready;
  assign cur_ov   = sel ? b16.out_valid : b8.out_valid;
  assign cur_cout = sel ? b16.cout      : b8.cout;
  assign cur_sum  = sel ? b16.sum       : {8'h00, b8.sum};
`ifdef SERIAL_ADDER_OVF_EN
  logic cur_ovf;
  assign cur_ovf = sel ? b16.ovf : b8.ovf;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic op(input logic w16, input logic [15:0] a, input logic [15:0] b, input logic c,
                    input int hold, output logic [15:0] rs, output logic rc);
    int          w, n, lat;
    logic [15:0] mask, am, bm;
    logic [16:0] e, ex;
    w    = w16 ? 16 : 8;
    mask = w16 ? 16'hFFFF : 16'h00FF;
    am   = a & mask;
    bm   = b & mask;
    sel  = w16;
    @(negedge clk);
    a_drv = am; b_drv = bm; cin_drv = c; iv = 1'b1; ordy = 1'b0;
    n = 0;
    while (!cur_ir && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cur_ir) begin
      tests++;
      fails++;
      $display("FAIL accept: in_ready low for %0d cycles", n);
      iv = 1'b0; rs = '0; rc = 1'b0;
      return;
    end
    sbq.push_back({1'b0, am} + {1'b0, bm} + 17'(c));
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    while (!cur_ov && lat < 200) begin
      iv    = 1'($urandom_range(0, 1));
      a_drv = 16'($urandom);
      ordy  = 1'($urandom_range(0, 1));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    iv = 1'b0; ordy = 1'b0;
    chk("latency", lat, w);
    e  = sbq.pop_front();
    ex = w16 ? e : {e[8], 8'h00, e[7:0]};
    chk("result", {15'd0, cur_cout, cur_sum}, {15'd0, ex});
    rs = cur_sum; rc = cur_cout;
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", cur_ovf, (am[w-1] == bm[w-1]) && (e[w-1] != am[w-1]));
`endif
    repeat (hold) begin
      iv    = 1'($urandom_range(0, 1));
      a_drv = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", cur_ov, 1);
      chk("hold_ready", cur_ir, 0);
      chk("hold_result", {cur_cout, cur_sum}, {rc, rs});
    end
    iv = 1'b0; ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy = 1'b0;
    chk("ready_back", cur_ir, 1);
    chk("valid_drop", cur_ov, 0);
    chk("retain", {cur_cout, cur_sum}, {rc, rs});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rs;
    logic        rc;
    int          n;
    tbl[0] = '{8'h3C, 8'h45, 1'b0, 8'h81, 1'b0};
    tbl[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_ready8", b8.in_ready, 1);
    chk("rst_valid8", b8.out_valid, 0);
    chk("rst_busy8", b8.busy, 0);
    chk("rst_result8", {b8.cout, b8.sum}, 0);
    chk("rst_ready16", b16.in_ready, 1);
    chk("rst_result16", {b16.cout, b16.sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      op(1'b0, {8'h00, tbl[i].a}, {8'h00, tbl[i].b}, tbl[i].cin, (i == 0) ? 5 : 1, rs, rc);
      chk("tbl_sum", rs, {8'h00, tbl[i].sum});
      chk("tbl_cout", rc, tbl[i].cout);
    end
    sel = 1'b0;
    @(negedge clk);
    a_drv = 16'h0055; b_drv = 16'h0033; cin_drv = 1'b0; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_busy", b8.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", b8.in_ready, 1);
    chk("mid_rst_valid", b8.out_valid, 0);
    chk("mid_rst_busy", b8.busy, 0);
    chk("mid_rst_result", {b8.cout, b8.sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (b8.out_valid) n++;
    end
    chk("no_stale", n, 0);
    op(1'b0, 16'h0012, 16'h0034, 1'b1, 0, rs, rc);
    chk("post_rst_sum", {rc, rs}, 17'h00047);
    op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 2, rs, rc);
    chk("w16_ones", {rc, rs}, 17'h1FFFF);
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op(i >= 500, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3), rs, rc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
